rv32i_exu_ctrl: RTL and testbench
=================================

# rv32i_exu_ctrl
Execute-stage controller that sequences the RV32I ALU: holds the one-entry ID/EX pipeline register, selects and forwards ALU operands, detects load-use hazards, applies valid/ready handshakes toward decode and MEM, and resolves branches and jumps into a PC redirect. It sits between the decode stage and the MEM stage and drives the ALU operand/opcode inputs.
## Interface
- WORD_WTH, 32, data/PC width
- REG_INX_WTH, 5, register index width
- ALU_OP_WTH, 5, ALU opcode width
- clk_i  in  1  clock, rising edge
- rst_n_i  in  1  asynchronous, active-low reset
- id_valid_i  in  1  decode offers an instruction
- id_ready_o  out  1  EX can accept
- id_pc_i  in  WORD_WTH  instruction PC
- id_rs1_data_i  in  WORD_WTH  register-file rs1 value
- id_rs2_data_i  in  WORD_WTH  register-file rs2 value
- id_imm_i  in  WORD_WTH  sign-extended immediate
- id_rs1_inx_i  in  REG_INX_WTH  rs1 index; decode drives 0 when rs1 is unused
- id_rs2_inx_i  in  REG_INX_WTH  rs2 index; decode drives 0 when rs2 is unused
- id_rd_inx_i  in  REG_INX_WTH  destination index
- id_ctrl_i  in  8  bit 0 rd_we, 1 src1_pc, 2 src2_imm, 3 branch, 4 jal, 5 jalr, 6 load, 7 store
- id_alu_op_i  in  ALU_OP_WTH  ALU opcode (ADD for load/store/jump)
- mem_fwd_inx_i  in  REG_INX_WTH  MEM-stage rd; 0 means no write
- mem_fwd_data_i  in  WORD_WTH  MEM-stage result
- mem_is_load_i  in  1  MEM-stage instruction is a load (data not yet available)
- wb_fwd_inx_i  in  REG_INX_WTH  WB-stage rd; 0 means no write
- wb_fwd_data_i  in  WORD_WTH  WB-stage writeback data
- alu_data1_o  out  WORD_WTH  ALU operand 1
- alu_data2_o  out  WORD_WTH  ALU operand 2
- alu_opcode_o  out  ALU_OP_WTH  ALU opcode
- alu_res_i  in  WORD_WTH  ALU result
- alu_br_taken_i  in  1  ALU branch compare result
- ex_valid_o  out  1  result valid toward MEM
- ex_ready_i  in  1  MEM accepts
- ex_res_o  out  WORD_WTH  ALU result (address for load/store, PC+4 for jumps)
- ex_st_data_o  out  WORD_WTH  forwarded rs2 (store data)
- ex_rd_inx_o  out  REG_INX_WTH  destination index
- ex_ctrl_o  out  8  id_ctrl_i of the held entry
- redirect_o  out  1  single-cycle PC redirect pulse
- redirect_pc_o  out  WORD_WTH  redirect target
## Operation
- State: a valid bit plus registered fields. rs1_fwd/rs2_fwd: if the index is nonzero and equals mem_fwd_inx_i, use mem_fwd_data_i. Otherwise, if it equals wb_fwd_inx_i, use wb_fwd_data_i. Otherwise use the held register value. MEM has priority over WB. Index 0 is never forwarded.
- load_use = valid && mem_is_load_i && mem_fwd_inx_i!=0 && (mem_fwd_inx_i==rs1 || mem_fwd_inx_i==rs2).
- ex_valid_o = valid && !load_use. fire = ex_valid_o && ex_ready_i. id_ready_o = !valid || fire.
- alu_data1_o = (src1_pc|jal|jalr) ? pc : rs1_fwd. alu_data2_o = (jal|jalr) ? 4 : src2_imm ? imm : rs2_fwd. alu_opcode_o = held op. ex_res_o = alu_res_i. ex_st_data_o = rs2_fwd.
- redirect_o = fire && (jal || jalr || (branch && alu_br_taken_i)). redirect_pc_o = (rs1_fwd+imm) with bit 0 cleared for jalr, else pc+imm. Addition is modulo 2^WORD_WTH.
- Update at each edge:
  - If redirect_o: valid<=0, and any simultaneous id handshake is discarded. Decode treats redirect_o as its own flush.
  - Else if id_valid_i && id_ready_o: capture all id_* fields, valid<=1.
  - Else if fire: valid<=0.
  - Else if valid (held by load_use or !ex_ready_i): rs1/rs2 data registers <= rs1_fwd/rs2_fwd, so a producer retiring from WB during the hold is not lost.
- Reset state: valid=0, all fields 0. Consequently id_ready_o=1, ex_valid_o=0, redirect_o=0, and all data outputs are 0.
## Timing
- One instruction per cycle when there are no hazards. Combinational paths: forwarding → ALU operands → ex_res_o/redirect_o, all within the same cycle. Load-use inserts exactly one bubble (ex_valid_o=0) once the load is in WB.
- The reset assertion clears the entry asynchronously mid-operation. The redirect pulse is never repeated for the same entry.
## Test plan
- ADD, rs1=x5 (mem_fwd_inx=5, data 0x10), rs2=x6 (reg 0x20), wb_fwd_inx=5 (data 0x99) -> alu_data1_o=0x10, ex_res_o=0x30, ex_valid_o=1.
- Load in MEM writing x5, EX uses x5 -> ex_valid_o=0 and id_ready_o=0 for one cycle; next cycle wb_fwd_inx=5, data 0x7 -> alu_data1_o=0x7, fire.
- BEQ, pc=0x100, imm=0x20, alu_br_taken_i=1, ex_ready_i=1, id_valid_i=1 -> redirect_o=1 for one cycle, redirect_pc_o=0x120, next cycle valid=0 (id instruction dropped).
- JALR, pc=0x100, rs1=0x203, imm=0x4 -> redirect_pc_o=0x206, ex_res_o=0x104, ex_ctrl_o bit 0 = 1.
- Producer x7=0x55 in WB, ex_ready_i=0 for 3 cycles while WB moves on -> after release alu_data1_o=0x55. Reset during the hold -> ex_valid_o=0, id_ready_o=1 immediately.

Source files
------------

// File: rtl/rv32i_exu_ctrl.sv
// -----------------------------------------------------------------------------
// rv32i_exu_ctrl
//
// Execute-stage controller for an RV32I pipeline. Holds the single ID/EX
// entry, forwards MEM/WB results into the ALU operands, stalls on load-use,
// handshakes with decode (id_*) and MEM (ex_*), and turns taken branches and
// jumps into a one-cycle PC redirect.
//
// Ports
//   clk_i, rst_n_i        clock (rising edge), asynchronous active-low reset
//   id_valid_i/id_ready_o decode handshake
//   id_pc_i .. id_alu_op_i instruction fields captured into the ID/EX entry
//   id_ctrl_i             [0] rd_we [1] src1_pc [2] src2_imm [3] branch
//                         [4] jal   [5] jalr    [6] load     [7] store
//   mem_fwd_*/mem_is_load_i  MEM-stage forwarding source (inx 0 = no write)
//   wb_fwd_*              WB-stage forwarding source (inx 0 = no write)
//   alu_data1_o/alu_data2_o/alu_opcode_o  ALU operand/opcode drive
//   alu_res_i/alu_br_taken_i              ALU result and branch compare
//   ex_valid_o/ex_ready_i MEM handshake
//   ex_res_o/ex_st_data_o/ex_rd_inx_o/ex_ctrl_o  payload toward MEM
//   redirect_o/redirect_pc_o                     PC redirect pulse and target
// -----------------------------------------------------------------------------
module rv32i_exu_ctrl #(
    parameter int WORD_WTH    = 32,
    parameter int REG_INX_WTH = 5,
    parameter int ALU_OP_WTH  = 5
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,

    // decode side
    input  logic                   id_valid_i,
    output logic                   id_ready_o,
    input  logic [WORD_WTH-1:0]    id_pc_i,
    input  logic [WORD_WTH-1:0]    id_rs1_data_i,
    input  logic [WORD_WTH-1:0]    id_rs2_data_i,
    input  logic [WORD_WTH-1:0]    id_imm_i,
    input  logic [REG_INX_WTH-1:0] id_rs1_inx_i,
    input  logic [REG_INX_WTH-1:0] id_rs2_inx_i,
    input  logic [REG_INX_WTH-1:0] id_rd_inx_i,
    input  logic [7:0]             id_ctrl_i,
    input  logic [ALU_OP_WTH-1:0]  id_alu_op_i,

    // forwarding sources
    input  logic [REG_INX_WTH-1:0] mem_fwd_inx_i,
    input  logic [WORD_WTH-1:0]    mem_fwd_data_i,
    input  logic                   mem_is_load_i,
    input  logic [REG_INX_WTH-1:0] wb_fwd_inx_i,
    input  logic [WORD_WTH-1:0]    wb_fwd_data_i,

    // ALU
    output logic [WORD_WTH-1:0]    alu_data1_o,
    output logic [WORD_WTH-1:0]    alu_data2_o,
    output logic [ALU_OP_WTH-1:0]  alu_opcode_o,
    input  logic [WORD_WTH-1:0]    alu_res_i,
    input  logic                   alu_br_taken_i,

    // MEM side
    output logic                   ex_valid_o,
    input  logic                   ex_ready_i,
    output logic [WORD_WTH-1:0]    ex_res_o,
    output logic [WORD_WTH-1:0]    ex_st_data_o,
    output logic [REG_INX_WTH-1:0] ex_rd_inx_o,
    output logic [7:0]             ex_ctrl_o,

    // fetch redirect
    output logic                   redirect_o,
    output logic [WORD_WTH-1:0]    redirect_pc_o
);

    // control-word bit positions
    localparam int C_RD_WE    = 0;
    localparam int C_SRC1_PC  = 1;
    localparam int C_SRC2_IMM = 2;
    localparam int C_BRANCH   = 3;
    localparam int C_JAL      = 4;
    localparam int C_JALR     = 5;

    localparam int NUM_SRC = 2;

    // -------------------------------------------------------------------------
    // ID/EX entry
    // -------------------------------------------------------------------------
    logic                   r_valid;
    logic [WORD_WTH-1:0]    r_pc;
    logic [WORD_WTH-1:0]    r_rs1_data;
    logic [WORD_WTH-1:0]    r_rs2_data;
    logic [WORD_WTH-1:0]    r_imm;
    logic [REG_INX_WTH-1:0] r_rs1_inx;
    logic [REG_INX_WTH-1:0] r_rs2_inx;
    logic [REG_INX_WTH-1:0] r_rd_inx;
    logic [7:0]             r_ctrl;
    logic [ALU_OP_WTH-1:0]  r_alu_op;

    // -------------------------------------------------------------------------
    // Operand forwarding, one lane per source register (0 = rs1, 1 = rs2)
    // -------------------------------------------------------------------------
    logic [NUM_SRC-1:0][REG_INX_WTH-1:0] w_src_inx;
    logic [NUM_SRC-1:0][WORD_WTH-1:0]    w_src_reg;
    logic [NUM_SRC-1:0][WORD_WTH-1:0]    w_src_fwd;
    logic [NUM_SRC-1:0]                  w_src_mem_hit;
    logic [NUM_SRC-1:0]                  w_src_wb_hit;

    assign w_src_inx[0] = r_rs1_inx;
    assign w_src_inx[1] = r_rs2_inx;
    assign w_src_reg[0] = r_rs1_data;
    assign w_src_reg[1] = r_rs2_data;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_fwd
            // x0 is hard-wired zero, so it never matches a producer even if
            // a stage reports index 0 alongside non-zero data.
            assign w_src_mem_hit[gi] = (w_src_inx[gi] != '0) &&
                                       (w_src_inx[gi] == mem_fwd_inx_i);
            assign w_src_wb_hit[gi]  = (w_src_inx[gi] != '0) &&
                                       (w_src_inx[gi] == wb_fwd_inx_i);
            // MEM is younger than WB, so it wins when both match.
            assign w_src_fwd[gi] = w_src_mem_hit[gi] ? mem_fwd_data_i :
                                   w_src_wb_hit[gi]  ? wb_fwd_data_i  :
                                                       w_src_reg[gi];
        end
    endgenerate

    logic [WORD_WTH-1:0] w_rs1_fwd;
    logic [WORD_WTH-1:0] w_rs2_fwd;

    assign w_rs1_fwd = w_src_fwd[0];
    assign w_rs2_fwd = w_src_fwd[1];

    // -------------------------------------------------------------------------
    // Hazard and handshake
    // -------------------------------------------------------------------------
    logic w_load_use;
    logic w_ex_valid;
    logic w_fire;
    logic w_id_ready;
    logic w_id_take;

    // A load in MEM has no data yet; any match against it must wait a cycle
    // until the value reaches WB.
    assign w_load_use = r_valid && mem_is_load_i && (|w_src_mem_hit);
    assign w_ex_valid = r_valid && !w_load_use;
    assign w_fire     = w_ex_valid && ex_ready_i;
    assign w_id_ready = !r_valid || w_fire;
    assign w_id_take  = id_valid_i && w_id_ready;

    // -------------------------------------------------------------------------
    // ALU operand selection
    // -------------------------------------------------------------------------
    logic w_is_jump;
    logic w_is_jalr;
    logic w_is_branch;

    assign w_is_jump   = r_ctrl[C_JAL] | r_ctrl[C_JALR];
    assign w_is_jalr   = r_ctrl[C_JALR];
    assign w_is_branch = r_ctrl[C_BRANCH];

    // Jumps reuse the ALU to produce the link value pc+4; the target comes
    // from the dedicated adder below.
    assign alu_data1_o  = (r_ctrl[C_SRC1_PC] | w_is_jump) ? r_pc : w_rs1_fwd;
    assign alu_data2_o  = w_is_jump          ? WORD_WTH'(4) :
                          r_ctrl[C_SRC2_IMM] ? r_imm        :
                                               w_rs2_fwd;
    assign alu_opcode_o = r_alu_op;

    // -------------------------------------------------------------------------
    // Redirect target
    // -------------------------------------------------------------------------
    logic [WORD_WTH-1:0] w_tgt_base;
    logic [WORD_WTH-1:0] w_tgt_sum;
    logic                w_redirect;

    assign w_tgt_base = w_is_jalr ? w_rs1_fwd : r_pc;
    assign w_tgt_sum  = w_tgt_base + r_imm;

    // jalr targets are forced to halfword alignment by clearing bit 0.
    assign redirect_pc_o = w_is_jalr ? {w_tgt_sum[WORD_WTH-1:1], 1'b0}
                                     : w_tgt_sum;

    // Qualified by fire so the pulse appears exactly once per entry: the
    // entry is released on that same edge.
    assign w_redirect = w_fire && (w_is_jump || (w_is_branch && alu_br_taken_i));
    assign redirect_o = w_redirect;

    // -------------------------------------------------------------------------
    // Outputs toward decode / MEM
    // -------------------------------------------------------------------------
    assign id_ready_o   = w_id_ready;
    assign ex_valid_o   = w_ex_valid;
    assign ex_res_o     = alu_res_i;
    assign ex_st_data_o = w_rs2_fwd;
    assign ex_rd_inx_o  = r_rd_inx;
    assign ex_ctrl_o    = r_ctrl;

    // -------------------------------------------------------------------------
    // Entry update
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_rs1_inx  <= '0;
            r_rs2_inx  <= '0;
            r_rd_inx   <= '0;
            r_ctrl     <= '0;
            r_alu_op   <= '0;
        end else if (w_redirect) begin
            // The instruction offered by decode this cycle is on the wrong
            // path; decode flushes itself on redirect_o, so it is dropped.
            r_valid <= 1'b0;
        end else if (w_id_take) begin
            r_valid    <= 1'b1;
            r_pc       <= id_pc_i;
            r_rs1_data <= id_rs1_data_i;
            r_rs2_data <= id_rs2_data_i;
            r_imm      <= id_imm_i;
            r_rs1_inx  <= id_rs1_inx_i;
            r_rs2_inx  <= id_rs2_inx_i;
            r_rd_inx   <= id_rd_inx_i;
            r_ctrl     <= id_ctrl_i;
            r_alu_op   <= id_alu_op_i;
        end else if (w_fire) begin
            r_valid <= 1'b0;
        end else if (r_valid) begin
            // Stalled: latch the forwarded values so a producer that leaves
            // WB while we wait is not lost.
            r_rs1_data <= w_rs1_fwd;
            r_rs2_data <= w_rs2_fwd;
        end
    end

endmodule

// File: tb/tb_rv32i_exu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rv32i_exu_ctrl
//
// Directed bench for rv32i_exu_ctrl. A small ALU model closes the loop on the
// ALU ports. A behavioural model of the ID/EX entry predicts every output each
// cycle; a set of hand-computed literal checks pins the key scenarios.
// -----------------------------------------------------------------------------
module tb_rv32i_exu_ctrl;

    localparam int W  = 32;
    localparam int RI = 5;
    localparam int OW = 5;

    localparam logic [OW-1:0] OP_ADD = 5'd0;
    localparam logic [OW-1:0] OP_SUB = 5'd1;
    localparam logic [OW-1:0] OP_XOR = 5'd2;

    localparam logic [7:0] C_WE   = 8'h01;
    localparam logic [7:0] C_PC   = 8'h02;
    localparam logic [7:0] C_IMM  = 8'h04;
    localparam logic [7:0] C_BR   = 8'h08;
    localparam logic [7:0] C_JAL  = 8'h10;
    localparam logic [7:0] C_JALR = 8'h20;
    localparam logic [7:0] C_LD   = 8'h40;
    localparam logic [7:0] C_ST   = 8'h80;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          id_valid;
    logic          id_ready;
    logic [W-1:0]  id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [RI-1:0] id_rs1_inx, id_rs2_inx, id_rd_inx;
    logic [7:0]    id_ctrl;
    logic [OW-1:0] id_alu_op;
    logic [RI-1:0] mem_fwd_inx, wb_fwd_inx;
    logic [W-1:0]  mem_fwd_data, wb_fwd_data;
    logic          mem_is_load;
    logic [W-1:0]  alu_d1, alu_d2, alu_res;
    logic [OW-1:0] alu_op;
    logic          alu_br_taken;
    logic          ex_valid, ex_ready;
    logic [W-1:0]  ex_res, ex_st_data;
    logic [RI-1:0] ex_rd_inx;
    logic [7:0]    ex_ctrl;
    logic          redirect;
    logic [W-1:0]  redirect_pc;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rv32i_exu_ctrl #(.WORD_WTH(W), .REG_INX_WTH(RI), .ALU_OP_WTH(OW)) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .id_valid_i     (id_valid),
        .id_ready_o     (id_ready),
        .id_pc_i        (id_pc),
        .id_rs1_data_i  (id_rs1_data),
        .id_rs2_data_i  (id_rs2_data),
        .id_imm_i       (id_imm),
        .id_rs1_inx_i   (id_rs1_inx),
        .id_rs2_inx_i   (id_rs2_inx),
        .id_rd_inx_i    (id_rd_inx),
        .id_ctrl_i      (id_ctrl),
        .id_alu_op_i    (id_alu_op),
        .mem_fwd_inx_i  (mem_fwd_inx),
        .mem_fwd_data_i (mem_fwd_data),
        .mem_is_load_i  (mem_is_load),
        .wb_fwd_inx_i   (wb_fwd_inx),
        .wb_fwd_data_i  (wb_fwd_data),
        .alu_data1_o    (alu_d1),
        .alu_data2_o    (alu_d2),
        .alu_opcode_o   (alu_op),
        .alu_res_i      (alu_res),
        .alu_br_taken_i (alu_br_taken),
        .ex_valid_o     (ex_valid),
        .ex_ready_i     (ex_ready),
        .ex_res_o       (ex_res),
        .ex_st_data_o   (ex_st_data),
        .ex_rd_inx_o    (ex_rd_inx),
        .ex_ctrl_o      (ex_ctrl),
        .redirect_o     (redirect),
        .redirect_pc_o  (redirect_pc)
    );

    // ALU stand-in; the branch compare is driven directly by the stimulus.
    function automatic logic [W-1:0] alu_fn(logic [OW-1:0] op, logic [W-1:0] a, logic [W-1:0] b);
        case (op)
            OP_SUB:  return a - b;
            OP_XOR:  return a ^ b;
            default: return a + b;
        endcase
    endfunction

    assign alu_res = alu_fn(alu_op, alu_d1, alu_d2);

    task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Behavioural model
    // -------------------------------------------------------------------------
    typedef struct {
        bit            valid;
        logic [W-1:0]  pc, rs1, rs2, imm;
        logic [RI-1:0] i1, i2, rd;
        logic [7:0]    ctrl;
        logic [OW-1:0] op;
    } entry_t;

    typedef struct {
        bit           id_ready, ex_valid, fire, redirect;
        logic [W-1:0] v1, v2, d1, d2, res, rpc;
    } exp_t;

    entry_t m;

    // Newest producer of a register wins; x0 always reads the stored value.
    function automatic logic [W-1:0] read_reg(logic [RI-1:0] r, logic [W-1:0] held);
        if (r == 0)           return held;
        if (r == mem_fwd_inx) return mem_fwd_data;
        if (r == wb_fwd_inx)  return wb_fwd_data;
        return held;
    endfunction

    function automatic exp_t predict();
        exp_t e;
        bit   jump, waits_on_load;
        e.v1 = read_reg(m.i1, m.rs1);
        e.v2 = read_reg(m.i2, m.rs2);
        waits_on_load = mem_is_load && mem_fwd_inx != 0 &&
                        (mem_fwd_inx == m.i1 || mem_fwd_inx == m.i2);
        e.ex_valid = m.valid && !waits_on_load;
        e.fire     = e.ex_valid && ex_ready;
        e.id_ready = !m.valid || e.fire;
        jump = (m.ctrl & (C_JAL | C_JALR)) != 0;
        e.d1 = (jump || (m.ctrl & C_PC) != 0) ? m.pc : e.v1;
        if (jump)                   e.d2 = 4;
        else if ((m.ctrl & C_IMM) != 0) e.d2 = m.imm;
        else                        e.d2 = e.v2;
        e.res = alu_fn(m.op, e.d1, e.d2);
        if ((m.ctrl & C_JALR) != 0) e.rpc = ((e.v1 + m.imm) / 2) * 2;
        else                        e.rpc = m.pc + m.imm;
        e.redirect = e.fire && (jump || ((m.ctrl & C_BR) != 0 && alu_br_taken));
        return e;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        exp_t e;
        if (!rst_n) begin
            m <= '{default: 0};
        end else begin
            e = predict();
            if (e.fire)
                $display("txn pc=%h res=%h rd=%0d ctrl=%h redirect=%0d tgt=%h",
                         m.pc, e.res, m.rd, m.ctrl, e.redirect, e.rpc);
            if (e.redirect)
                m.valid <= 1'b0;
            else if (id_valid && e.id_ready)
                m <= '{1'b1, id_pc, id_rs1_data, id_rs2_data, id_imm,
                       id_rs1_inx, id_rs2_inx, id_rd_inx, id_ctrl, id_alu_op};
            else if (e.fire)
                m.valid <= 1'b0;
            else if (m.valid) begin
                m.rs1 <= e.v1;
                m.rs2 <= e.v2;
            end
        end
    end

    // Every-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        e = predict();
        chk("id_ready", W'(id_ready), W'(e.id_ready));
        chk("ex_valid", W'(ex_valid), W'(e.ex_valid));
        chk("redirect", W'(redirect), W'(e.redirect));
        if (m.valid) begin
            chk("alu_data1",   alu_d1,          e.d1);
            chk("alu_data2",   alu_d2,          e.d2);
            chk("alu_opcode",  W'(alu_op),      W'(m.op));
            chk("ex_res",      ex_res,          e.res);
            chk("ex_st_data",  ex_st_data,      e.v2);
            chk("ex_rd_inx",   W'(ex_rd_inx),   W'(m.rd));
            chk("ex_ctrl",     W'(ex_ctrl),     W'(m.ctrl));
            chk("redirect_pc", redirect_pc,     e.rpc);
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(logic [W-1:0] pc, logic [W-1:0] d1, logic [W-1:0] d2,
                         logic [W-1:0] imm, logic [RI-1:0] i1, logic [RI-1:0] i2,
                         logic [RI-1:0] rd, logic [7:0] ctrl, logic [OW-1:0] op);
        id_valid    = 1'b1;
        id_pc       = pc;
        id_rs1_data = d1;
        id_rs2_data = d2;
        id_imm      = imm;
        id_rs1_inx  = i1;
        id_rs2_inx  = i2;
        id_rd_inx   = rd;
        id_ctrl     = ctrl;
        id_alu_op   = op;
    endtask

    initial begin
        id_valid = 0; id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
        id_rs1_inx = 0; id_rs2_inx = 0; id_rd_inx = 0; id_ctrl = 0; id_alu_op = 0;
        mem_fwd_inx = 0; mem_fwd_data = 0; mem_is_load = 0;
        wb_fwd_inx = 0; wb_fwd_data = 0;
        alu_br_taken = 0; ex_ready = 1;

        // reset state
        #2;
        chk("rst id_ready", W'(id_ready), 1);
        chk("rst ex_valid", W'(ex_valid), 0);
        chk("rst redirect", W'(redirect), 0);
        chk("rst alu_data1", alu_d1, 0);
        chk("rst ex_res", ex_res, 0);
        chk("rst ex_ctrl", W'(ex_ctrl), 0);
        chk("rst redirect_pc", redirect_pc, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;

        // ADD with MEM and WB both producing x5: MEM wins
        offer(32'h40, 32'h1111, 32'h20, 0, 5, 6, 8, C_WE, OP_ADD);
        tick();
        id_valid = 0;
        mem_fwd_inx = 5; mem_fwd_data = 32'h10;
        wb_fwd_inx = 5;  wb_fwd_data = 32'h99;
        #1;
        chk("fwd alu_data1", alu_d1, 32'h10);
        chk("fwd ex_res", ex_res, 32'h30);
        chk("fwd ex_valid", W'(ex_valid), 1);
        tick();

        // load-use: one bubble, then value from WB
        mem_fwd_inx = 0; wb_fwd_inx = 0;
        offer(32'h44, 32'hAAAA, 0, 1, 5, 0, 9, C_WE | C_IMM, OP_ADD);
        tick();
        mem_fwd_inx = 5; mem_fwd_data = 32'hDEAD; mem_is_load = 1;
        offer(32'h100, 3, 3, 32'h20, 1, 2, 0, C_BR, OP_SUB);
        #1;
        chk("lu ex_valid", W'(ex_valid), 0);
        chk("lu id_ready", W'(id_ready), 0);
        tick();
        mem_fwd_inx = 0; mem_is_load = 0;
        wb_fwd_inx = 5; wb_fwd_data = 32'h7;
        #1;
        chk("lu alu_data1", alu_d1, 32'h7);
        chk("lu ex_res", ex_res, 32'h8);
        chk("lu fire ex_valid", W'(ex_valid), 1);
        chk("lu id_ready", W'(id_ready), 1);
        tick();

        // taken BEQ, simultaneous offer is dropped
        wb_fwd_inx = 0;
        alu_br_taken = 1;
        offer(32'h200, 1, 1, 0, 1, 2, 4, C_WE, OP_ADD);
        #1;
        chk("beq redirect", W'(redirect), 1);
        chk("beq redirect_pc", redirect_pc, 32'h120);
        tick();
        alu_br_taken = 0;
        id_valid = 0;
        #1;
        chk("beq drop ex_valid", W'(ex_valid), 0);
        chk("beq no repeat", W'(redirect), 0);
        chk("beq id_ready", W'(id_ready), 1);

        // JALR
        offer(32'h100, 32'h203, 0, 4, 3, 0, 1, C_WE | C_JALR, OP_ADD);
        tick();
        id_valid = 0;
        #1;
        chk("jalr redirect_pc", redirect_pc, 32'h206);
        chk("jalr ex_res", ex_res, 32'h104);
        chk("jalr rd_we", W'(ex_ctrl[0]), 1);
        chk("jalr redirect", W'(redirect), 1);
        tick();

        // store with WB-forwarded data, followed by a not-taken branch
        offer(32'h300, 32'h1000, 32'hBAD, 8, 10, 11, 0, C_ST | C_IMM, OP_ADD);
        tick();
        wb_fwd_inx = 11; wb_fwd_data = 32'hCAFE;
        offer(32'h304, 1, 2, 32'h40, 12, 13, 0, C_BR, OP_SUB);
        #1;
        chk("st data", ex_st_data, 32'hCAFE);
        chk("st addr", ex_res, 32'h1008);
        tick();
        wb_fwd_inx = 0;
        id_valid = 0;
        #1;
        chk("bnt redirect", W'(redirect), 0);
        chk("bnt ex_valid", W'(ex_valid), 1);
        tick();

        // JAL backwards
        offer(32'h400, 0, 0, 32'hFFFF_FFF0, 0, 0, 1, C_WE | C_JAL, OP_ADD);
        tick();
        id_valid = 0;
        #1;
        chk("jal redirect_pc", redirect_pc, 32'h3F0);
        chk("jal ex_res", ex_res, 32'h404);
        chk("jal alu_data2", alu_d2, 4);
        tick();

        // MEM back-pressure while the producer leaves WB
        offer(32'h500, 0, 0, 0, 7, 0, 2, C_WE, OP_ADD);
        tick();
        id_valid = 0;
        ex_ready = 0;
        wb_fwd_inx = 7; wb_fwd_data = 32'h55;
        tick();
        wb_fwd_inx = 9; wb_fwd_data = 32'h66;
        tick();
        tick();
        ex_ready = 1; wb_fwd_inx = 0;
        #1;
        chk("hold alu_data1", alu_d1, 32'h55);
        chk("hold ex_valid", W'(ex_valid), 1);
        tick();

        // asynchronous reset during a hold
        offer(32'h600, 32'h77, 0, 0, 2, 0, 3, C_WE, OP_ADD);
        tick();
        id_valid = 0;
        ex_ready = 0;
        #2;
        chk("pre-rst ex_valid", W'(ex_valid), 1);
        rst_n = 0;
        #1;
        chk("mid-rst ex_valid", W'(ex_valid), 0);
        chk("mid-rst id_ready", W'(id_ready), 1);
        tick();
        rst_n = 1;
        ex_ready = 1;

        // back-to-back stream; x0 is never forwarded, load to x0 never stalls
        mem_fwd_inx = 0; mem_fwd_data = 32'hEEEE; mem_is_load = 1;
        wb_fwd_inx = 0;  wb_fwd_data = 32'hFFFF;
        offer(32'h700, 32'hF0, 32'h5, 0, 4, 0, 5, C_WE, OP_XOR);
        tick();
        offer(32'h704, 32'h1, 32'h2, 32'h10, 0, 6, 6, C_WE | C_PC | C_IMM, OP_ADD);
        #1;
        chk("x0 st_data", ex_st_data, 32'h5);
        chk("x0 ex_res", ex_res, 32'hF5);
        tick();
        offer(32'h708, 32'h9, 32'h4, 0, 8, 9, 7, C_WE, OP_SUB);
        #1;
        chk("auipc ex_res", ex_res, 32'h714);
        tick();
        id_valid = 0;
        mem_is_load = 0;
        #1;
        chk("sub ex_res", ex_res, 32'h5);
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
